// File: rtl/uart_tx_feeder_if.sv
// Parallel launch link between the feeder and the UART TX control FSM.
// The feeder is the master: it presents the byte and the launch pulse, the TX FSM answers with busy.
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_data_valid;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_busy;

  modport master (output tx_data_valid, output tx_p_data, input tx_busy);
  modport slave  (input tx_data_valid, input tx_p_data, output tx_busy);
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART TX FSM: launches one byte at a time and waits for the
// frame to finish; a launch that never raises busy is abandoned after a short watchdog.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   S_IDLE      | waiting for a queued byte and tx_busy low; pops on exit
//   S_LAUNCH    | tx_data_valid high for this one cycle, watchdog cleared
//   S_WAIT_BUSY | waiting for the TX FSM to raise busy (watchdog running)
//   S_WAIT_DONE | frame in flight, waiting for busy to fall
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  uart_tx_feeder_if.master       tx,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx_lost
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [1:0]            wd_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push;
  logic                  pop;

  // Full is judged on the pre-edge count, so a same-cycle pop never admits a write into a full FIFO.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == S_IDLE) && !empty && !tx.tx_busy;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state            <= S_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      wd_cnt           <= '0;
      overflow         <= 1'b0;
      tx_lost          <= 1'b0;
      tx.tx_data_valid <= 1'b0;
      tx.tx_p_data     <= '0;
    end else begin
      overflow         <= wr_en && full;
      tx_lost          <= 1'b0;
      tx.tx_data_valid <= 1'b0;

      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;

      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            tx.tx_p_data     <= mem[rd_ptr];
            tx.tx_data_valid <= 1'b1;
            state            <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wd_cnt <= '0;
          state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx.tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (wd_cnt == 2'd2) begin
            // Count reaches 3 here: the launch cycle plus three waiting cycles saw no busy.
            wd_cnt  <= 2'd3;
            tx_lost <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 2'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx.tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
